// File: rtl/uart_frame_check.sv
// UART RX frame checker: validates start, optional parity and stop bits of one
// frame, assembles the data word LSB-first and counts errored frames.
module uart_frame_check #(
  parameter int DATA_WIDTH = 8,  // 5..9
  parameter int STOP_BITS  = 1,  // 1 or 2
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  start_err,
  output logic                  par_err,
  output logic                  stop_err,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  frame_done_q, frame_done_d;
  logic                  start_err_q, start_err_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  // Frame FSM: next state, bit assembly, parity and error flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    par_acc_d    = par_acc_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    frame_done_d = 1'b0;
    start_err_d  = start_err_q;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;

    unique case (state_q)
      S_IDLE: begin
        // A bit_valid in the accepting cycle is not the start bit.
        if (frame_start) begin
          state_d     = S_START;
          data_d      = '0;
          start_err_d = 1'b0;
          par_err_d   = 1'b0;
          stop_err_d  = 1'b0;
          par_en_d    = par_en;
          par_type_d  = par_type;
        end
      end
      S_START: begin
        if (bit_valid) begin
          if (sampled_bit) begin
            // Aborted frame: nothing after the start bit is checked.
            start_err_d  = 1'b1;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (bit_valid) begin
          // data_q was cleared at frame accept, so OR-ing places the bit.
          data_d    = data_q | (DATA_WIDTH'(sampled_bit) << bit_cnt_q);
          par_acc_d = par_acc_q ^ sampled_bit;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_valid) begin
          par_err_d = (sampled_bit != (par_acc_q ^ par_type_q));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_valid) begin
          if (!sampled_bit) stop_err_d = 1'b1;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating error counter; bumps in the frame_done cycle, clear wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (frame_done_q && (start_err_q || par_err_q || stop_err_q)
                 && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      par_acc_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      par_acc_q    <= par_acc_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign data_out   = data_q;
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;
  assign par_err    = par_err_q;
  assign stop_err   = stop_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
